gate_bist: RTL and testbench

- Synthesizable built-in self-test engine for small combinational gate blocks, e.g. 2-input / multi-output gate arrays.
- Replaces free-running toggle stimulus with a clocked, parametrised exhaustive sweep of all 2^IN_W input vectors.
- Compares DUT outputs against a golden-model output bus and reports pass/fail, error count and first failing vector.
- Sits between the DUT and its golden model on the lab board or in simulation.

---
 rtl/gate_bist.sv | 126 ++++++++++++
 tb/tb_gate_bist.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// Exhaustive-sweep BIST engine for small combinational gate blocks: drives all 2^IN_W vectors,
// compares DUT against golden outputs. Optional compare mask enabled by defining GATE_BIST_MASK_EN.
module gate_bist #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 5,
  parameter int DWELL = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic [IN_W-1:0]  Inp_Vec,
  input  logic [OUT_W-1:0] Dut_Out,
  input  logic [OUT_W-1:0] Gold_Out,
`ifdef GATE_BIST_MASK_EN
  input  logic [OUT_W-1:0] Cmp_Mask,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [IN_W:0]    Err_Cnt,
  output logic             First_Err_Vld,
  output logic [IN_W-1:0]  First_Err_Vec
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  // vec runs one bit wider than Inp_Vec so the last-vector test never wraps at IN_W=16
  localparam logic [IN_W:0] LAST_VEC = {1'b0, {IN_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IN_W:0]   vec_q, vec_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [IN_W:0]   err_cnt_q, err_cnt_d;
  logic            first_vld_q, first_vld_d;
  logic [IN_W-1:0] first_vec_q, first_vec_d;
  logic [OUT_W-1:0] diff;
  logic            mismatch;
  logic            sample;

  always_comb begin
`ifdef GATE_BIST_MASK_EN
    diff = (Dut_Out ^ Gold_Out) & Cmp_Mask;
`else
    diff = Dut_Out ^ Gold_Out;
`endif
    mismatch = |diff;
    sample   = (dwell_q == DWELL_LAST);
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    dwell_d     = dwell_q;
    err_cnt_d   = err_cnt_q;
    first_vld_d = first_vld_q;
    first_vec_d = first_vec_q;
    case (state_q)
      IDLE, FIN: begin
        if (Start) begin
          state_d     = RUN;
          vec_d       = '0;
          dwell_d     = '0;
          err_cnt_d   = '0;
          first_vld_d = 1'b0;
          first_vec_d = '0;
        end
      end
      RUN: begin
        if (!sample) begin
          dwell_d = dwell_q + DW_W'(1);
        end else begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + (IN_W+1)'(1);
            if (!first_vld_q) begin
              first_vld_d = 1'b1;
              first_vec_d = vec_q[IN_W-1:0];
            end
          end
          // Last vector keeps its value so Inp_Vec holds it through FIN
          if (vec_q == LAST_VEC) begin
            state_d = FIN;
          end else begin
            vec_d   = vec_q + (IN_W+1)'(1);
            dwell_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      dwell_q     <= '0;
      err_cnt_q   <= '0;
      first_vld_q <= 1'b0;
      first_vec_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      dwell_q     <= dwell_d;
      err_cnt_q   <= err_cnt_d;
      first_vld_q <= first_vld_d;
      first_vec_q <= first_vec_d;
    end
  end

  always_comb begin
    Inp_Vec       = vec_q[IN_W-1:0];
    Busy          = (state_q == RUN);
    Done          = (state_q == FIN);
    Pass          = (state_q == FIN) && (err_cnt_q == '0);
    Err_Cnt       = err_cnt_q;
    First_Err_Vld = first_vld_q;
    First_Err_Vec = first_vec_q;
  end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist with a 2-input gate array {NOR,NAND,XOR,OR,AND} as DUT and golden model.
module tb_gate_bist;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic [1:0] Inp_Vec;
  logic [4:0] Dut_Out;
  logic [4:0] Gold_Out;
  logic       Busy, Done, Pass, First_Err_Vld;
  logic [2:0] Err_Cnt;
  logic [1:0] First_Err_Vec;
`ifdef GATE_BIST_MASK_EN
  logic [4:0] Cmp_Mask = 5'b11111;
`endif

  int checks = 0;
  int failures = 0;
  int fault_mode = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    Gold_Out = {~(Inp_Vec[1] | Inp_Vec[0]), ~(Inp_Vec[1] & Inp_Vec[0]),
                Inp_Vec[1] ^ Inp_Vec[0], Inp_Vec[1] | Inp_Vec[0], Inp_Vec[1] & Inp_Vec[0]};
    Dut_Out = Gold_Out;
    if (fault_mode == 1) Dut_Out[0] = 1'b0;
    if (fault_mode == 2) Dut_Out[2] = 1'b1;
  end

  gate_bist #(.IN_W(2), .OUT_W(5), .DWELL(2)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Inp_Vec(Inp_Vec),
    .Dut_Out(Dut_Out), .Gold_Out(Gold_Out),
`ifdef GATE_BIST_MASK_EN
    .Cmp_Mask(Cmp_Mask),
`endif
    .Busy(Busy), .Done(Done), .Pass(Pass), .Err_Cnt(Err_Cnt),
    .First_Err_Vld(First_Err_Vld), .First_Err_Vec(First_Err_Vec)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Pulses Start for one edge; returns just after the edge that accepted it.
  task automatic start_pulse();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // Walks the 8 RUN cycles recording whether Busy and Inp_Vec followed 0,0,1,1,2,2,3,3.
  task automatic run_sweep(input int start_at, output bit seq_ok);
    seq_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (Busy !== 1'b1 || Done !== 1'b0 || Inp_Vec !== 2'(i / 2)) seq_ok = 1'b0;
      if (i == start_at) Start = 1'b1;
      step();
      Start = 1'b0;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step();
    step();
    checks++;
    if ({Inp_Vec, Busy, Done, Pass, Err_Cnt, First_Err_Vld, First_Err_Vec} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0",
               {Inp_Vec, Busy, Done, Pass, Err_Cnt, First_Err_Vld, First_Err_Vec});
    end
    Rst = 1'b0;
    step();
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b done=%b expected 0 0", Busy, Done);
    end
  endtask

  task automatic test_clean_sweep();
    bit ok;
    fault_mode = 0;
    start_pulse();
    run_sweep(-1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clean_sequence got=0 expected=1");
    end
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || Pass !== 1'b1 || Err_Cnt !== 3'd0 || First_Err_Vld !== 1'b0) begin
      failures++;
      $display("FAIL clean_result done=%b busy=%b pass=%b err=%0d fvld=%b expected 1 0 1 0 0",
               Done, Busy, Pass, Err_Cnt, First_Err_Vld);
    end
    step();
    checks++;
    if (Done !== 1'b1 || Inp_Vec !== 2'd3) begin
      failures++;
      $display("FAIL fin_hold done=%b vec=%0d expected 1 3", Done, Inp_Vec);
    end
  endtask

  task automatic test_and_stuck0();
    bit ok;
    fault_mode = 1;
    start_pulse();
    run_sweep(-1, ok);
    checks++;
    if (!ok || Err_Cnt !== 3'd1 || First_Err_Vld !== 1'b1 || First_Err_Vec !== 2'd3 || Pass !== 1'b0 || Done !== 1'b1) begin
      failures++;
      $display("FAIL and_stuck0 seq=%b err=%0d fvld=%b fvec=%0d pass=%b done=%b expected 1 1 1 3 0 1",
               ok, Err_Cnt, First_Err_Vld, First_Err_Vec, Pass, Done);
    end
  endtask

  task automatic test_xor_stuck1();
    bit ok;
    fault_mode = 2;
    start_pulse();
    run_sweep(-1, ok);
    checks++;
    if (!ok || Err_Cnt !== 3'd2 || First_Err_Vld !== 1'b1 || First_Err_Vec !== 2'd0 || Pass !== 1'b0) begin
      failures++;
      $display("FAIL xor_stuck1 seq=%b err=%0d fvld=%b fvec=%0d pass=%b expected 1 2 1 0 0",
               ok, Err_Cnt, First_Err_Vld, First_Err_Vec, Pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    fault_mode = 2;
    start_pulse();
    step();
    step();
    Rst = 1'b1;
    Start = 1'b1;
    step();
    Rst = 1'b0;
    Start = 1'b0;
    checks++;
    if ({Inp_Vec, Busy, Done, Pass, Err_Cnt, First_Err_Vld, First_Err_Vec} !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset got=%h expected=0",
               {Inp_Vec, Busy, Done, Pass, Err_Cnt, First_Err_Vld, First_Err_Vec});
    end
    step();
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle busy=%b done=%b expected 0 0", Busy, Done);
    end
    fault_mode = 0;
    start_pulse();
    run_sweep(-1, ok);
    checks++;
    if (!ok || Done !== 1'b1 || Pass !== 1'b1 || Err_Cnt !== 3'd0) begin
      failures++;
      $display("FAIL after_reset_sweep seq=%b done=%b pass=%b err=%0d expected 1 1 1 0", ok, Done, Pass, Err_Cnt);
    end
  endtask

  task automatic test_start_handling();
    bit ok;
    fault_mode = 1;
    start_pulse();
    run_sweep(3, ok);
    checks++;
    if (!ok || Done !== 1'b1 || Err_Cnt !== 3'd1) begin
      failures++;
      $display("FAIL start_ignored seq=%b done=%b err=%0d expected 1 1 1", ok, Done, Err_Cnt);
    end
    fault_mode = 0;
    start_pulse();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1 || Err_Cnt !== 3'd0 || First_Err_Vld !== 1'b0 || Inp_Vec !== 2'd0) begin
      failures++;
      $display("FAIL fin_restart done=%b busy=%b err=%0d fvld=%b vec=%0d expected 0 1 0 0 0",
               Done, Busy, Err_Cnt, First_Err_Vld, Inp_Vec);
    end
    run_sweep(-1, ok);
    checks++;
    if (!ok || Pass !== 1'b1 || Done !== 1'b1) begin
      failures++;
      $display("FAIL restart_sweep seq=%b pass=%b done=%b expected 1 1 1", ok, Pass, Done);
    end
  endtask

`ifdef GATE_BIST_MASK_EN
  task automatic test_mask();
    bit ok;
    fault_mode = 2;
    Cmp_Mask = 5'b11011;
    start_pulse();
    run_sweep(-1, ok);
    checks++;
    if (!ok || Err_Cnt !== 3'd0 || Pass !== 1'b1) begin
      failures++;
      $display("FAIL mask_xor seq=%b err=%0d pass=%b expected 1 0 1", ok, Err_Cnt, Pass);
    end
    Cmp_Mask = 5'b11111;
    start_pulse();
    run_sweep(-1, ok);
    checks++;
    if (!ok || Err_Cnt !== 3'd2 || Pass !== 1'b0) begin
      failures++;
      $display("FAIL mask_full seq=%b err=%0d pass=%b expected 1 2 0", ok, Err_Cnt, Pass);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_clean_sweep();
    test_and_stuck0();
    test_xor_stuck1();
    test_reset_mid_sweep();
    test_start_handling();
`ifdef GATE_BIST_MASK_EN
    test_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
